// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared fixed-point opcodes, format constants and saturation limits
package fxp_pkg;

    localparam int FXP_WIDTH = 8;
    localparam int FXP_FRAC  = 6;

    localparam logic signed [FXP_WIDTH-1:0] FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic signed [FXP_WIDTH-1:0] FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        FXP_ADD   = 2'b00,
        FXP_SUB   = 2'b01,
        FXP_MUL   = 2'b10,
        FXP_PASSA = 2'b11
    } fxp_op_e;

endpackage

// File: rtl/fxp_sat_alu.sv
// rtl/fxp_sat_alu.sv - combinational saturating fixed-point ADD/SUB/MUL/PASSA unit
module fxp_sat_alu
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC
) (
    input  fxp_op_e                  i_op,
    input  logic signed [WIDTH-1:0]  i_a,
    input  logic signed [WIDTH-1:0]  i_b,
    output logic        [WIDTH-1:0]  o_data,
    output logic                     o_ovf
);

    localparam int WW = 2 * WIDTH;

    logic signed [WIDTH:0]  w_sum;
    logic signed [WIDTH:0]  w_diff;
    logic signed [WW-1:0]   w_prod;
    logic signed [WW-1:0]   w_wide;
    logic        [WIDTH:0]  w_top;

    assign w_sum  = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    assign w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    assign w_prod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});

    // Every op is widened to 2*WIDTH so one range check covers all of them.
    always_comb begin
        w_wide = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        case (i_op)
            FXP_ADD:   w_wide = {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
            FXP_SUB:   w_wide = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
            FXP_MUL:   w_wide = w_prod >>> FRAC;
            default:   w_wide = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        endcase
    end

    // In range only when the bits above the result's sign bit all match it.
    assign w_top  = w_wide[WW-1:WIDTH-1];
    assign o_ovf  = !((&w_top) || !(|w_top));
    assign o_data = !o_ovf ? w_wide[WIDTH-1:0] :
                    w_wide[WW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

endmodule

// File: rtl/fxp_alu_arbiter.sv
// rtl/fxp_alu_arbiter.sv - round-robin sharing of one saturating fixed-point ALU between NREQ requesters
module fxp_alu_arbiter
    import fxp_pkg::*;
#(
    parameter  int WIDTH = FXP_WIDTH,
    parameter  int FRAC  = FXP_FRAC,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_ovf
);

    logic [IDW-1:0]          r_ptr;
    logic                    r_s1_v;
    fxp_op_e                 r_s1_op;
    logic signed [WIDTH-1:0] r_s1_a;
    logic signed [WIDTH-1:0] r_s1_b;
    logic [IDW-1:0]          r_s1_id;
    logic                    r_rsp_valid;
    logic [IDW-1:0]          r_rsp_id;
    logic [WIDTH-1:0]        r_rsp_data;
    logic                    r_rsp_ovf;

    logic                    w_any;
    logic [IDW-1:0]          w_grant;
    int                      w_idx;
    logic                    w_s2_free;
    logic                    w_s1_free;
    logic                    w_accept;
    logic [IDW-1:0]          w_ptr_nxt;
    fxp_op_e                 w_sel_op;
    logic [WIDTH-1:0]        w_sel_a;
    logic [WIDTH-1:0]        w_sel_b;
    logic [WIDTH-1:0]        w_alu_data;
    logic                    w_alu_ovf;

    // First valid requester at or after the priority pointer, wrapping at NREQ.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = IDW'(w_idx);
            end
        end
    end

    assign w_s2_free = !r_rsp_valid || rsp_ready;
    assign w_s1_free = !r_s1_v || w_s2_free;
    assign w_accept  = w_any && w_s1_free && !rst;
    assign req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;
    assign w_ptr_nxt = (int'(w_grant) == NREQ - 1) ? '0 : w_grant + 1'b1;

    assign w_sel_op = fxp_op_e'(req_op[2*int'(w_grant) +: 2]);
    assign w_sel_a  = req_a[WIDTH*int'(w_grant) +: WIDTH];
    assign w_sel_b  = req_b[WIDTH*int'(w_grant) +: WIDTH];

    fxp_sat_alu #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_alu (
        .i_op   (r_s1_op),
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_data (w_alu_data),
        .o_ovf  (w_alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_v      <= 1'b0;
            r_s1_op     <= FXP_ADD;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_ovf   <= 1'b0;
        end else begin
            // S1 is free when empty or when its content moves to S2 this edge.
            if (w_s1_free) begin
                r_s1_v <= w_accept;
                if (w_accept) begin
                    r_s1_op <= w_sel_op;
                    r_s1_a  <= w_sel_a;
                    r_s1_b  <= w_sel_b;
                    r_s1_id <= w_grant;
                end
            end
            if (w_accept) r_ptr <= w_ptr_nxt;
            if (w_s2_free) begin
                r_rsp_valid <= r_s1_v;
                if (r_s1_v) begin
                    r_rsp_id   <= r_s1_id;
                    r_rsp_data <= w_alu_data;
                    r_rsp_ovf  <= w_alu_ovf;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_fxp_alu_arbiter.sv
// tb/tb_fxp_alu_arbiter.sv - scoreboard bench for fxp_alu_arbiter with directed vectors
module tb_fxp_alu_arbiter;
    import fxp_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_ovf;

    fxp_alu_arbiter #(.WIDTH(W), .FRAC(6), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    int         acc_ids[$];
    int         checks = 0;
    int         errors = 0;
    int         acc_cnt = 0;
    int         m_ptr = 0;
    logic [7:0] e_data[NREQ];
    logic       e_ovf[NREQ];

    // Acceptance observer: checks the grant against a round-robin model and pushes expectations.
    always @(negedge clk) begin : observer
        int g;
        int idx;
        if (rst) begin
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL ready_in_reset: req_ready=%b required 0000", req_ready);
            end
            m_ptr = 0;
        end else if (req_ready !== '0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            checks++;
            if (g < 0 || req_ready !== (4'b0001 << g)) begin
                errors++;
                $display("FAIL grant: req_ready=%b required grant index %0d (valid=%b ptr=%0d)",
                         req_ready, g, req_valid, m_ptr);
            end
            if (g >= 0) begin
                sb.push_back('{id: 2'(g), data: e_data[g], ovf: e_ovf[g]});
                acc_ids.push_back(g);
                acc_cnt++;
                m_ptr = (g + 1) % NREQ;
            end
        end
    end

    logic       prev_stall = 1'b0;
    logic [7:0] p_data;
    logic [1:0] p_id;
    logic       p_ovf;

    // Response monitor: stall stability and in-order comparison against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(rsp_valid && rsp_data == p_data && rsp_id == p_id && rsp_ovf == p_ovf)) begin
                    errors++;
                    $display("FAIL hold: valid=%b id=%0d data=%h ovf=%b required valid=1 id=%0d data=%h ovf=%b",
                             rsp_valid, rsp_id, rsp_data, rsp_ovf, p_id, p_data, p_ovf);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: id=%0d data=%h ovf=%b required no response",
                             rsp_id, rsp_data, rsp_ovf);
                end else begin
                    e = sb.pop_front();
                    if (rsp_id !== e.id || rsp_data !== e.data || rsp_ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL rsp: id=%0d data=%h ovf=%b required id=%0d data=%h ovf=%b",
                                 rsp_id, rsp_data, rsp_ovf, e.id, e.data, e.ovf);
                    end
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            p_data = rsp_data;
            p_id   = rsp_id;
            p_ovf  = rsp_ovf;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic set_req(input int i, input fxp_op_e op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ed, input logic eo);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        e_data[i]        = ed;
        e_ovf[i]         = eo;
    endtask

    task automatic single(input int i, input fxp_op_e op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eo);
        int n;
        @(posedge clk);
        #1;
        set_req(i, op, a, b, ed, eo);
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 20);
        check("single_accept_timeout", int'(req_ready[i]), 1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        @(posedge clk);
        #1 check("latency_rsp_valid", int'(rsp_valid), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        check("drain_leftover", sb.size(), 0);
    endtask

    task automatic rr_vectors();
        set_req(0, FXP_MUL, 8'h40, 8'h40, 8'h40, 1'b0);
        set_req(1, FXP_MUL, 8'hC0, 8'h20, 8'hE0, 1'b0);
        set_req(2, FXP_ADD, 8'h60, 8'h60, 8'h7F, 1'b1);
        set_req(3, FXP_SUB, 8'h80, 8'h01, 8'h80, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int n0;
        int exp_seq[6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rr_vectors();
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_ovf", int'(rsp_ovf), 0);

        // Round-robin with all requesters active and the consumer always ready.
        rst = 1'b0;
        cyc = 0;
        while (acc_cnt < 6 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        #1 req_valid = '0;
        check("rr_cycles_for_6", cyc, 6);
        for (int k = 0; k < 6; k++)
            check("rr_id_seq", (k < acc_ids.size()) ? acc_ids[k] : -1, exp_seq[k]);
        drain();

        single(0, FXP_MUL,   8'h40, 8'h40, 8'h40, 1'b0);
        single(0, FXP_MUL,   8'hC0, 8'h20, 8'hE0, 1'b0);
        single(0, FXP_MUL,   8'h60, 8'h60, 8'h7F, 1'b1);
        single(0, FXP_ADD,   8'h60, 8'h60, 8'h7F, 1'b1);
        single(0, FXP_SUB,   8'h80, 8'h01, 8'h80, 1'b1);
        single(0, FXP_ADD,   8'h10, 8'hF0, 8'h00, 1'b0);
        single(2, FXP_PASSA, 8'h85, 8'h7F, 8'h85, 1'b0);
        drain();

        // Backpressure: consumer stalls for 5 cycles under continuous requests.
        rr_vectors();
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = '1;
        base = acc_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("bp_accept_count", acc_cnt - base, 2);
        check("bp_ready_zero", int'(req_ready), 0);
        rsp_ready = 1'b1;
        cyc = 0;
        while (acc_cnt < base + 6 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        #1 req_valid = '0;
        check("bp_accept_total", acc_cnt - base, 6);
        drain();

        // Reset with both stages full, then first grant goes to the lowest valid index.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midreset_rsp_valid", int'(rsp_valid), 0);
        rst       = 1'b0;
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        n0 = acc_ids.size();
        cyc = 0;
        while (acc_ids.size() == n0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        #1 req_valid = '0;
        check("post_reset_first_grant", (acc_ids.size() > n0) ? acc_ids[n0] : -1, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
